pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage: holds the PC register and selects the next PC from sequential increment, branch target, jump target or exception vector. It generalises the two-way branch/PC mux to a four-source priority selection and adds a stall/ready-aware one-deep redirect buffer. A redirect raised while fetch cannot advance is kept, not lost. Sits between the branch/jump resolution logic and the instruction memory address port.

---
 rtl/pc_seq_pkg.sv | 8 +
 rtl/pc_sequencer_if.sv | 10 +
 rtl/pc_redirect_arbiter.sv | 35 +++
 rtl/pc_sequencer.sv | 58 +++++
 tb/tb_pc_sequencer.sv | 82 ++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: redirect source priorities, sequencer states and the target alignment check.
package pc_seq_pkg;
  typedef enum logic [1:0] {SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_EXC} src_e;
  typedef enum logic {RUN, PEND} state_e;
  function automatic logic misaligned(input logic [63:0] a, input int unsigned bits);
    return (a & ((64'd1 << bits) - 64'd1)) != 64'd0;
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect inputs and fetch-address outputs of the PC sequencer.
interface pc_sequencer_if #(parameter int WIDTH = 32);
  logic stall, fetch_ready, branch_taken, jump, exception;
  logic [WIDTH-1:0] branch_target, jump_target, pc_out, pc_plus_inc;
  logic pc_valid, redirect_pending, misalign;
  modport master (output stall, fetch_ready, branch_taken, branch_target, jump, jump_target, exception,
                  input pc_out, pc_valid, pc_plus_inc, redirect_pending, misalign);
  modport slave (input stall, fetch_ready, branch_taken, branch_target, jump, jump_target, exception,
                 output pc_out, pc_valid, pc_plus_inc, redirect_pending, misalign);
endinterface

// File: rtl/pc_redirect_arbiter.sv
// pc_redirect_arbiter: picks the next-PC source and target from live inputs and the pending buffer.
module pc_redirect_arbiter
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic             i_valid,
  input  logic             i_branch,
  input  logic [WIDTH-1:0] i_branch_tgt,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_tgt,
  input  logic             i_exc,
  input  logic [WIDTH-1:0] i_seq_tgt,
  input  src_e             i_buf_src,
  input  logic [WIDTH-1:0] i_buf_tgt,
  output src_e             o_src,
  output logic [WIDTH-1:0] o_tgt,
  output logic             o_misalign
);
  src_e w_raw_src, w_in_src;
  logic [WIDTH-1:0] w_raw_tgt, w_in_tgt;
  logic w_mis, w_use_in;
  assign w_raw_src = !i_valid ? SRC_SEQ : i_exc ? SRC_EXC : i_jump ? SRC_JUMP : i_branch ? SRC_BRANCH : SRC_SEQ;
  assign w_raw_tgt = i_jump ? i_jump_tgt : i_branch_tgt;
  assign w_mis = (w_raw_src == SRC_JUMP || w_raw_src == SRC_BRANCH) && misaligned(64'(w_raw_tgt), ALIGN_BITS);
  assign w_in_src = w_mis ? SRC_EXC : w_raw_src;
  assign w_in_tgt = (w_in_src == SRC_EXC) ? EXC_VECTOR : (w_in_src == SRC_SEQ) ? i_seq_tgt : w_raw_tgt;
  // An empty buffer holds SRC_SEQ, so the live input always wins in RUN; ties favour the live input.
  assign w_use_in = w_in_src >= i_buf_src;
  assign o_src = w_use_in ? w_in_src : i_buf_src;
  assign o_tgt = w_use_in ? w_in_tgt : i_buf_tgt;
  assign o_misalign = w_mis & w_use_in;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with prioritised redirects and a one-deep redirect buffer.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] INC = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter int unsigned ALIGN_BITS = 2
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  state_e r_state, w_state_nx;
  src_e r_buf_src, w_sel_src;
  logic [WIDTH-1:0] r_pc, r_buf_tgt, w_sel_tgt, w_pc_inc;
  logic r_valid, w_advance, w_misalign;
  assign w_advance = r_valid & ~bus.stall & bus.fetch_ready;
  assign w_pc_inc = r_pc + INC;
  pc_redirect_arbiter #(.WIDTH(WIDTH), .EXC_VECTOR(EXC_VECTOR), .ALIGN_BITS(ALIGN_BITS)) u_arb (
    .i_valid(r_valid),
    .i_branch(bus.branch_taken),
    .i_branch_tgt(bus.branch_target),
    .i_jump(bus.jump),
    .i_jump_tgt(bus.jump_target),
    .i_exc(bus.exception),
    .i_seq_tgt(w_pc_inc),
    .i_buf_src(r_buf_src),
    .i_buf_tgt(r_buf_tgt),
    .o_src(w_sel_src),
    .o_tgt(w_sel_tgt),
    .o_misalign(w_misalign)
  );
  always_comb begin
    w_state_nx = w_advance ? RUN : (w_sel_src != SRC_SEQ) ? PEND : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_pc      <= RESET_VECTOR;
      r_valid   <= 1'b0;
      r_buf_src <= SRC_SEQ;
      r_buf_tgt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_valid   <= 1'b1;
      r_buf_src <= w_advance ? SRC_SEQ : w_sel_src;
      r_buf_tgt <= w_advance ? '0 : w_sel_tgt;
      if (w_advance) r_pc <= w_sel_tgt;
    end
  end
  assign bus.pc_out = r_pc;
  assign bus.pc_valid = r_valid;
  assign bus.pc_plus_inc = w_pc_inc;
  assign bus.redirect_pending = (r_state == PEND);
  assign bus.misalign = w_misalign;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; per-cycle expectations are queued at drive time and popped after the edge.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [33:0] sb_q[$];
  pc_sequencer_if #(.WIDTH(32)) b();
  pc_sequencer_if #(.WIDTH(32)) b2();
  pc_sequencer u_dut (.clk(clk), .rst_n(rst_n), .bus(b));
  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rn, input logic st, input logic fr, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt, input logic ex, input logic emis,
                     input logic [31:0] epc, input logic ev, input logic ep);
    logic [33:0] e;
    @(negedge clk);
    rst_n = rn; b.stall = st; b.fetch_ready = fr; b.branch_taken = br; b.branch_target = bt;
    b.jump = jp; b.jump_target = jt; b.exception = ex;
    #1 chk("misalign", {31'd0, b.misalign}, {31'd0, emis});
    sb_q.push_back({ev, ep, epc});
    @(posedge clk);
    #1 e = sb_q.pop_front();
    chk("pc_out", b.pc_out, e[31:0]);
    chk("pc_plus_inc", b.pc_plus_inc, e[31:0] + 32'd4);
    chk("pc_valid", {31'd0, b.pc_valid}, {31'd0, e[33]});
    chk("redirect_pending", {31'd0, b.redirect_pending}, {31'd0, e[32]});
  endtask
  initial begin
    b.stall = 0; b.fetch_ready = 1; b.branch_taken = 0; b.branch_target = 0;
    b.jump = 0; b.jump_target = 0; b.exception = 0;
    b2.stall = 0; b2.fetch_ready = 1; b2.branch_taken = 0; b2.branch_target = 0;
    b2.jump = 0; b2.jump_target = 0; b2.exception = 0;
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(1, 0, 1, 0, 0, 1, 32'h900, 0, 0, 32'h0, 1, 0);
    chk("wrap_pc0", b2.pc_out, 32'hFFFF_FFF8);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    chk("wrap_pc1", b2.pc_out, 32'hFFFF_FFFC);
    chk("wrap_inc", b2.pc_plus_inc, 32'h0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0);
    chk("wrap_pc2", b2.pc_out, 32'h0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'hC, 1, 0);
    chk("wrap_pc3", b2.pc_out, 32'h4);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    cyc(1, 0, 1, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 0);
    cyc(1, 0, 1, 1, 32'h50, 1, 32'h100, 0, 0, 32'h100, 1, 0);
    cyc(1, 0, 1, 1, 32'h50, 1, 32'h100, 1, 0, 32'h8000_0180, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0184, 1, 0);
    cyc(1, 1, 1, 1, 32'h200, 0, 0, 0, 0, 32'h8000_0184, 1, 1);
    cyc(1, 1, 1, 0, 0, 1, 32'h300, 0, 0, 32'h8000_0184, 1, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h300, 1, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 0, 32'h300, 1, 1);
    cyc(1, 0, 1, 1, 32'h40, 0, 0, 0, 0, 32'h8000_0180, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0184, 1, 0);
    cyc(1, 1, 1, 0, 0, 1, 32'h500, 0, 0, 32'h8000_0184, 1, 1);
    cyc(1, 1, 1, 1, 32'h600, 0, 0, 0, 0, 32'h8000_0184, 1, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h500, 1, 0);
    cyc(1, 0, 0, 1, 32'h700, 0, 0, 0, 0, 32'h500, 1, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h700, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 32'h102, 0, 1, 32'h8000_0180, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0184, 1, 0);
    cyc(1, 1, 1, 1, 32'h41, 0, 0, 0, 1, 32'h8000_0184, 1, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0180, 1, 0);
    cyc(1, 1, 1, 0, 0, 1, 32'h900, 0, 0, 32'h8000_0180, 1, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
